// File: rtl/axil_imem_loader.sv
// AXI4-Lite slave that loads an instruction memory and holds the CPU in reset while loading.
// One transaction at a time; AW/W/AR each buffered in a one-entry holding register (ready = empty).
// Memory reads wait RD_LAT cycles; B/R responses hold until the master's ready handshake.
module axil_imem_loader #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_AW      = 14,
    parameter int RD_LAT      = 1,
    parameter int HOLD_CYCLES = 1024,
    parameter logic [ADDR_W-1:0] CTRL_ADDR = 32'hFFFF_FFF0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [2:0]          s_axi_awprot,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [2:0]          s_axi_arprot,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic                o_mem_en,
    output logic [DATA_W/8-1:0] o_mem_we,
    output logic [MEM_AW-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_cpu_rst_n,
    output logic                o_busy
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int CNT_W  = $clog2(HOLD_CYCLES + 1);
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(1) << (MEM_AW + LSB);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, WR, BRESP, RD, RWAIT, RRESP} state_t;

    state_t              state_q, state_d;
    logic                aw_full_q, w_full_q, ar_full_q;
    logic [ADDR_W-1:0]   aw_addr_q, ar_addr_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [STRB_W-1:0]   w_strb_q;
    logic                last_rd_q, grant_wr, grant_rd;
    logic [1:0]          lat_q;
    logic                bvalid_q, rvalid_q;
    logic [1:0]          bresp_q, rresp_q;
    logic [DATA_W-1:0]   rdata_q, status;
    logic                force_q, force_d;
    logic [CNT_W-1:0]    hold_q, hold_d;
    logic [15:0]         wr_cnt_q;
    logic                cpu_rst_n_q;
    logic                aw_mem, aw_ctrl, ar_mem, ar_ctrl, mem_wr, ctrl_wr;
    logic                unused_prot;

    function automatic logic is_mem(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < MEM_BYTES;
    endfunction

    function automatic logic is_ctrl(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:LSB] == CTRL_ADDR[ADDR_W-1:LSB];
    endfunction

    assign aw_mem  = is_mem(aw_addr_q);
    assign aw_ctrl = is_ctrl(aw_addr_q);
    assign ar_mem  = is_mem(ar_addr_q);
    assign ar_ctrl = is_ctrl(ar_addr_q);

    assign s_axi_awready = !aw_full_q;
    assign s_axi_wready  = !w_full_q;
    assign s_axi_arready = !ar_full_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign o_cpu_rst_n   = cpu_rst_n_q;
    assign o_busy        = (state_q != IDLE) | aw_full_q | w_full_q | ar_full_q;
    assign unused_prot   = ^{s_axi_awprot, s_axi_arprot};

    assign status = DATA_W'({wr_cnt_q, 13'd0, cpu_rst_n_q, hold_q != '0, force_q});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        grant_wr    = 1'b0;
        grant_rd    = 1'b0;
        o_mem_en    = 1'b0;
        o_mem_we    = '0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        case (state_q)
            IDLE: begin
                // Round-robin: a pending write wins only if the last grant went to a read.
                if (aw_full_q && w_full_q && (!ar_full_q || last_rd_q)) begin
                    grant_wr = 1'b1;
                    state_d  = WR;
                end else if (ar_full_q) begin
                    grant_rd = 1'b1;
                    state_d  = RD;
                end
            end
            WR: begin
                state_d = BRESP;
                if (aw_mem && (w_strb_q != '0)) begin
                    o_mem_en    = 1'b1;
                    o_mem_we    = w_strb_q;
                    o_mem_addr  = aw_addr_q[MEM_AW+LSB-1:LSB];
                    o_mem_wdata = w_data_q;
                end
            end
            BRESP: if (s_axi_bready) state_d = IDLE;
            RD: begin
                if (ar_mem) begin
                    o_mem_en   = 1'b1;
                    o_mem_addr = ar_addr_q[MEM_AW+LSB-1:LSB];
                    state_d    = RWAIT;
                end else begin
                    state_d = RRESP;
                end
            end
            RWAIT: if (lat_q == 2'(RD_LAT)) state_d = RRESP;
            RRESP: if (s_axi_rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            ar_full_q <= 1'b0;
            aw_addr_q <= '0;
            ar_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            last_rd_q <= 1'b1;
            lat_q     <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
        end else begin
            if (state_q == WR) begin
                aw_full_q <= 1'b0;
                w_full_q  <= 1'b0;
            end else begin
                if (s_axi_awvalid && !aw_full_q) begin
                    aw_full_q <= 1'b1;
                    aw_addr_q <= s_axi_awaddr;
                end
                if (s_axi_wvalid && !w_full_q) begin
                    w_full_q <= 1'b1;
                    w_data_q <= s_axi_wdata;
                    w_strb_q <= s_axi_wstrb;
                end
            end
            if (state_q == RD) begin
                ar_full_q <= 1'b0;
            end else if (s_axi_arvalid && !ar_full_q) begin
                ar_full_q <= 1'b1;
                ar_addr_q <= s_axi_araddr;
            end

            if (grant_wr) last_rd_q <= 1'b0;
            if (grant_rd) last_rd_q <= 1'b1;

            case (state_q)
                WR: begin
                    bvalid_q <= 1'b1;
                    bresp_q  <= (aw_mem || aw_ctrl) ? OKAY : SLVERR;
                end
                BRESP: if (s_axi_bready) bvalid_q <= 1'b0;
                RD: begin
                    lat_q <= 2'd1;
                    if (!ar_mem) begin
                        rvalid_q <= 1'b1;
                        rresp_q  <= ar_ctrl ? OKAY : SLVERR;
                        rdata_q  <= ar_ctrl ? status : '0;
                    end
                end
                RWAIT: begin
                    if (lat_q == 2'(RD_LAT)) begin
                        rvalid_q <= 1'b1;
                        rresp_q  <= OKAY;
                        rdata_q  <= i_mem_rdata;
                    end else begin
                        lat_q <= lat_q + 2'd1;
                    end
                end
                RRESP: if (s_axi_rready) rvalid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign mem_wr  = o_mem_en && (o_mem_we != '0);
    assign ctrl_wr = (state_q == WR) && !aw_mem && aw_ctrl && w_strb_q[0];

    // Writes carrying a RELEASE or CLR_CNT command leave FORCE_HOLD untouched,
    // so a release can drop the hold timer without dropping a forced hold.
    always_comb begin
        force_d = force_q;
        if (ctrl_wr && (w_data_q[2:1] == 2'b00)) force_d = w_data_q[0];
        hold_d = hold_q;
        if (mem_wr)                        hold_d = CNT_W'(HOLD_CYCLES);
        else if (ctrl_wr && w_data_q[1])   hold_d = '0;
        else if (hold_q != '0)             hold_d = hold_q - CNT_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            force_q     <= 1'b0;
            hold_q      <= '0;
            wr_cnt_q    <= '0;
            cpu_rst_n_q <= 1'b1;
        end else begin
            force_q     <= force_d;
            hold_q      <= hold_d;
            cpu_rst_n_q <= !(force_d || (hold_d != '0));
            if (mem_wr) begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            end else if (ctrl_wr && w_data_q[2]) begin
                wr_cnt_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_axil_imem_loader.sv
// Directed bench for axil_imem_loader with a byte-strobed memory model of read latency 2.
module tb_axil_imem_loader;
    localparam int HOLD = 8;
    localparam logic [31:0] CTRL = 32'hFFFF_FFF0;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
    logic [2:0]  s_axi_awprot, s_axi_arprot;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic [3:0]  s_axi_wstrb;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic        s_axi_rvalid, s_axi_rready;
    logic        o_mem_en;
    logic [3:0]  o_mem_we;
    logic [7:0]  o_mem_addr;
    logic [31:0] o_mem_wdata, i_mem_rdata;
    logic        o_cpu_rst_n, o_busy;

    int checks = 0;
    int failures = 0;

    axil_imem_loader #(
        .ADDR_W(32), .DATA_W(32), .MEM_AW(8), .RD_LAT(2),
        .HOLD_CYCLES(HOLD), .CTRL_ADDR(CTRL)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
        .o_cpu_rst_n(o_cpu_rst_n), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Memory model: data appears two cycles after the enable cycle.
    logic [31:0] mem [0:255];
    logic [31:0] pipe0, pipe1;
    assign i_mem_rdata = pipe1;
    always @(posedge i_clk) begin
        if (o_mem_en) begin
            for (int b = 0; b < 4; b++)
                if (o_mem_we[b]) mem[o_mem_addr][8*b +: 8] <= o_mem_wdata[8*b +: 8];
            pipe0 <= mem[o_mem_addr];
        end
        pipe1 <= pipe0;
    end

    // Monitors sample at the falling edge; the stimulus only reads these counters.
    int          en_cnt = 0;
    int          low_cnt = 0;
    int          rv_cnt = 0;
    logic        en_log[$];
    logic [3:0]  last_we = '0;
    logic [7:0]  last_addr = '0;
    logic [31:0] last_wdata = '0;
    always @(negedge i_clk) begin
        if (o_mem_en) begin
            en_cnt++;
            en_log.push_back(o_mem_we != 4'h0);
            if (o_mem_we != 4'h0) begin
                last_we    = o_mem_we;
                last_addr  = o_mem_addr;
                last_wdata = o_mem_wdata;
            end
        end
        if (i_rst_n && !o_cpu_rst_n) low_cnt++;
        if (s_axi_rvalid) rv_cnt++;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        int n;
        logic aw_hs, w_hs;
        n = 0;
        s_axi_awaddr = a; s_axi_awvalid = 1'b1;
        s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
        s_axi_bready = 1'b1;
        while ((s_axi_awvalid || s_axi_wvalid) && n < 60) begin
            aw_hs = s_axi_awready;
            w_hs  = s_axi_wready;
            tick(); n++;
            if (aw_hs) s_axi_awvalid = 1'b0;
            if (w_hs)  s_axi_wvalid = 1'b0;
        end
        while (!s_axi_bvalid && n < 60) begin tick(); n++; end
        resp = s_axi_bresp;
        chk("wr_timeout", 64'(n < 60), 64'd1);
        tick();
        s_axi_bready = 1'b0;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    endtask

    // Holds rready low for 'delay' cycles after rvalid and checks the response stays put.
    task automatic axi_read(input logic [31:0] a, input int delay,
                            output logic [31:0] d, output logic [1:0] resp);
        int n;
        logic hs;
        logic [33:0] first;
        n = 0;
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        while (s_axi_arvalid && n < 60) begin
            hs = s_axi_arready;
            tick(); n++;
            if (hs) s_axi_arvalid = 1'b0;
        end
        while (!s_axi_rvalid && n < 60) begin tick(); n++; end
        chk("rd_timeout", 64'(n < 60), 64'd1);
        first = {s_axi_rresp, s_axi_rdata};
        repeat (delay) tick();
        chk("r_stable", {s_axi_rvalid, s_axi_rresp, s_axi_rdata}, {1'b1, first});
        d = s_axi_rdata;
        resp = s_axi_rresp;
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        s_axi_arvalid = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        int n, en0, log0, rv0, awn, wn, arn;
        logic aw_hs, w_hs, ar_hs;

        i_rst_n = 1'b0;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        repeat (3) tick();
        chk("rst_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
        chk("rst_valid", {s_axi_bvalid, s_axi_rvalid, o_mem_en, o_mem_we}, 7'd0);
        chk("rst_cpu_busy", {o_cpu_rst_n, o_busy}, 2'b10);
        i_rst_n = 1'b1;
        tick();

        // AW alone, W three cycles later.
        en0 = en_cnt;
        s_axi_awaddr = 32'h10; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        chk("busy_aw_only", {o_busy, s_axi_awready, s_axi_wready}, 3'b101);
        tick(); tick();
        s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        tick();
        s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b1;
        n = 0;
        while (!s_axi_bvalid && n < 20) begin tick(); n++; end
        chk("w1_bresp", {s_axi_bvalid, s_axi_bresp}, 3'b100);
        tick();
        s_axi_bready = 1'b0;
        chk("w1_mem_port", {32'(en_cnt - en0), last_we, last_addr, last_wdata},
            {32'd1, 4'hF, 8'd4, 32'hDEAD_BEEF});
        n = 0;
        while (!o_cpu_rst_n && n < 40) begin tick(); n++; end
        chk("w1_hold_len", 64'(low_cnt), 64'(HOLD));

        // Read back with rready delayed 5 cycles.
        en0 = en_cnt;
        axi_read(32'h10, 5, rd, resp);
        chk("r1_data", {resp, rd}, {2'b00, 32'hDEAD_BEEF});
        chk("r1_done", {s_axi_rvalid, 32'(en_cnt - en0)}, {1'b0, 32'd1});

        // Write and read both pending: grants must alternate starting with the write.
        log0 = en_log.size();
        awn = 0; wn = 0; arn = 0; n = 0;
        s_axi_awaddr = 32'h20; s_axi_wdata = 32'h1111_2222; s_axi_wstrb = 4'hF;
        s_axi_araddr = 32'h20;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        while ((s_axi_awvalid || s_axi_wvalid || s_axi_arvalid) && n < 100) begin
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            ar_hs = s_axi_arvalid && s_axi_arready;
            tick(); n++;
            if (aw_hs) begin awn++; if (awn == 2) s_axi_awvalid = 1'b0; end
            if (w_hs)  begin wn++;  if (wn == 2)  s_axi_wvalid = 1'b0; end
            if (ar_hs) begin arn++; if (arn == 2) s_axi_arvalid = 1'b0; end
        end
        while (o_busy && n < 100) begin tick(); n++; end
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        chk("arb_count", 64'(en_log.size() - log0), 64'd4);
        if (en_log.size() - log0 == 4)
            chk("arb_order", {en_log[log0], en_log[log0+1], en_log[log0+2], en_log[log0+3]}, 4'b1010);

        // Control register: forced hold survives timer expiry and RELEASE.
        axi_write(CTRL, 32'h4, 4'h1, resp);
        chk("ctrl_clr_resp", resp, 2'b00);
        axi_write(CTRL, 32'h1, 4'h1, resp);
        chk("force_low", o_cpu_rst_n, 1'b0);
        axi_write(32'h40, 32'h0000_00A5, 4'h1, resp);
        repeat (HOLD + 5) tick();
        chk("force_after_hold", o_cpu_rst_n, 1'b0);
        axi_write(CTRL, 32'h2, 4'h1, resp);
        repeat (2) tick();
        chk("force_after_release", o_cpu_rst_n, 1'b0);
        axi_read(CTRL, 0, rd, resp);
        chk("status_forced", {resp, rd}, {2'b00, 32'h0001_0001});
        axi_write(CTRL, 32'h0, 4'h1, resp);
        repeat (2) tick();
        chk("unforce_high", o_cpu_rst_n, 1'b1);
        axi_read(CTRL, 1, rd, resp);
        chk("status_free", {resp, rd}, {2'b00, 32'h0001_0004});

        // Zero strobe and unmapped accesses: no memory access, no hold.
        en0 = en_cnt;
        axi_write(32'h44, 32'hFFFF_FFFF, 4'h0, resp);
        chk("zero_strb_resp", resp, 2'b00);
        axi_write(32'h8000_0000, 32'h1234_5678, 4'hF, resp);
        chk("unmapped_bresp", resp, 2'b10);
        axi_read(32'h8000_0000, 2, rd, resp);
        chk("unmapped_r", {resp, rd}, {2'b10, 32'h0});
        chk("unmapped_side", {32'(en_cnt - en0), o_cpu_rst_n}, {32'd0, 1'b1});

        // Reset while the read is waiting on memory latency.
        s_axi_araddr = 32'h10; s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        tick();
        chk("pre_rst_rd_en", {o_mem_en, o_mem_we}, 5'b10000);
        tick();
        en0 = en_cnt;
        rv0 = rv_cnt;
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_vals", {s_axi_rvalid, s_axi_bvalid, s_axi_bresp, s_axi_rresp, s_axi_rdata},
            {1'b0, 1'b0, 2'b00, 2'b00, 32'h0});
        chk("mid_rst_ctl", {o_busy, o_cpu_rst_n, s_axi_arready, o_mem_en}, 4'b0110);
        repeat (3) tick();
        i_rst_n = 1'b1;
        repeat (5) tick();
        chk("rst_no_resp", {32'(rv_cnt - rv0), 32'(en_cnt - en0)}, 64'd0);
        axi_read(CTRL, 0, rd, resp);
        chk("rst_status", rd, 32'h0000_0004);
        axi_write(32'h30, 32'hCAFE_F00D, 4'hF, resp);
        chk("post_rst_bresp", resp, 2'b00);
        axi_read(32'h30, 1, rd, resp);
        chk("post_rst_rd", {resp, rd}, {2'b00, 32'hCAFE_F00D});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axil_imem_loader.md
AXIL_IMEM_LOADER -- requirements
Module: axil_imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: AXI byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width, legal values 32 or 64; LSB = log2(DATA_W/8).
REQ-003 SHALL have parameter MEM_AW, default 14: memory word-address width.
REQ-004 SHALL have parameter RD_LAT, default 1: memory read latency, legal range 1..3.
REQ-005 SHALL have parameter HOLD_CYCLES, default 1024: CPU reset hold after the last memory write, minimum 1.
REQ-006 SHALL have parameter CTRL_ADDR, default 32'hFFFF_FFF0: byte address of the control/status register.
REQ-007 i_clk  in  1  single clock; all state updates on the rising edge.
REQ-008 i_rst_n  in  1  asynchronous, active-low reset.
REQ-009 s_axi_aw{addr,prot,valid}  in  ADDR_W/3/1; s_axi_awready  out  1: write-address channel; prot ignored.
REQ-010 s_axi_w{data,strb,valid}  in  DATA_W/DATA_W/8/1; s_axi_wready  out  1: write-data channel.
REQ-011 s_axi_b{resp,valid}  out  2/1; s_axi_bready  in  1: write-response channel.
REQ-012 s_axi_ar{addr,prot,valid}  in  ADDR_W/3/1; s_axi_arready  out  1: read-address channel.
REQ-013 s_axi_r{data,resp,valid}  out  DATA_W/2/1; s_axi_rready  in  1: read-data channel.
REQ-014 o_mem_en/o_mem_we/o_mem_addr/o_mem_wdata  out  1/DATA_W/8/MEM_AW/DATA_W: memory port; address is a word address.
REQ-015 i_mem_rdata  in  DATA_W: memory read data, valid RD_LAT cycles after a read-enable cycle.
REQ-016 o_cpu_rst_n  out  1: active-low CPU reset request; o_busy  out  1: high when any transaction is pending or active.

Function
REQ-017 AW, W and AR SHALL each be buffered in a one-entry holding register; each ready = holding register empty; channels are independent and may arrive in any order or in the same cycle.
REQ-018 The FSM SHALL have states IDLE, WR, BRESP, RD, RWAIT, RRESP, with one transaction outstanding at a time.
REQ-019 In IDLE, a write SHALL be eligible when AW and W are both held, and a read when AR is held; if both are eligible, the grant SHALL go opposite to the last grant (after reset, write wins first).
REQ-020 Address decode SHALL be: memory hit when addr < 2^MEM_AW * DATA_W/8; control hit when addr[ADDR_W-1:LSB] equals CTRL_ADDR[ADDR_W-1:LSB]; anything else is a decode error.
REQ-021 WR SHALL last 1 cycle. On a memory hit with wstrb != 0: o_mem_en=1, o_mem_we=wstrb, plus address and data, for exactly that cycle. wstrb == 0 SHALL cause no access and return OKAY. A decode error SHALL have no side effect and return SLVERR (2'b10). WR then frees AW and W and goes to BRESP.
REQ-022 BRESP and RRESP SHALL hold valid, resp and rdata stable until the ready handshake, then return to IDLE; holding registers MAY refill meanwhile.
REQ-023 RD on a memory hit SHALL pulse o_mem_en=1 with o_mem_we=0 for 1 cycle, then wait in RWAIT and capture i_mem_rdata exactly RD_LAT cycles after the enable cycle. On a control hit it SHALL return status with OKAY. On a decode error it SHALL return rdata=0 with SLVERR. The AR holding register SHALL be freed on leaving RD.
REQ-024 Control writes SHALL require wstrb[0]: bit0 FORCE_HOLD (sticky); bit1 RELEASE (zeroes the hold counter, not stored); bit2 CLR_CNT (zeroes the write count, not stored).
REQ-025 The status read SHALL be: bit0 FORCE_HOLD; bit1 (hold counter != 0); bit2 o_cpu_rst_n; [31:16] memory-write count, saturating at 16'hFFFF; all other bits 0.
REQ-026 The hold counter (width clog2(HOLD_CYCLES+1)) SHALL load HOLD_CYCLES on every memory-write cycle, including retriggers; otherwise it SHALL decrement while nonzero.
REQ-027 o_cpu_rst_n SHALL be registered as !(FORCE_HOLD_next | counter_next != 0): for a write enabled at cycle T, it is low from T+1 through T+HOLD_CYCLES and high at T+1+HOLD_CYCLES unless retriggered.
REQ-028 o_busy SHALL equal (state != IDLE) | any holding register full.

Reset
REQ-029 While i_rst_n=0, asynchronously: state=IDLE; holding registers empty; bvalid=rvalid=0; o_mem_en=0; o_mem_we=0; counter=0; FORCE_HOLD=0; write count=0; o_cpu_rst_n=1; last grant set to read; bresp, rresp and rdata = 0.
REQ-030 Reset asserted mid-transaction SHALL discard it with no response and no further memory access.

Verification
REQ-031 AW at cycle 0, W at cycle 3, addr 0x10, data 0xDEADBEEF, strb 0xF -> one o_mem_en cycle with we=0xF, addr=4; bresp=OKAY; o_cpu_rst_n low for exactly HOLD_CYCLES cycles.
REQ-032 Write 0x10, then read 0x10 with RD_LAT=2 and rready held low 5 cycles -> rdata=0xDEADBEEF stable until handshake, rresp=OKAY.
REQ-033 Write and read both pending in IDLE for 4 consecutive transactions -> grants alternate W,R,W,R.
REQ-034 Write CTRL_ADDR with 0x1, then memory write, then wait HOLD_CYCLES+5 -> o_cpu_rst_n stays 0; write 0x2 -> it stays 0; write 0x0 -> it goes 1; status bits[31:16]=1.
REQ-035 Write and read to unmapped address 0x8000_0000 -> SLVERR, rdata=0, no o_mem_en, o_cpu_rst_n unchanged.
REQ-036 Assert i_rst_n=0 during RWAIT -> rvalid never asserts; all REQ-029 values hold; first post-reset write completes normally.
